// File: rtl/lbp_uniform_decoder.sv
// Uniform-LBP label decoder: builds its label->code table after reset,
// then answers label lookups with one cycle of registered latency.
module lbp_uniform_decoder #(
    parameter logic [7:0] ERR_PATTERN = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] labelIn,
    input  logic       labelValid,
    output logic       ready,
    output logic [7:0] patternOut,
    output logic       patternValid,
    output logic       labelError
);

    typedef enum logic {
        BUILD,
        SERVE
    } state_t;

    localparam logic [5:0] LAST_LABEL = 6'd58;

    state_t     state;
    state_t     stateNext;
    logic [7:0] scanCode;
    logic [5:0] nextLabel;
    logic [7:0] tbl [0:58];
    logic       scanUniform;
    logic       lastCode;
    logic       accept;
    logic       lookupBad;
    logic [5:0] rdIdx;

    function automatic logic isUniform(input logic [7:0] c);
        logic [7:0] t;
        logic [3:0] n;
        t = c ^ {c[6:0], c[7]};
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, t[i]};
        end
        return n <= 4'd2;
    endfunction

    assign scanUniform = isUniform(scanCode);
    assign lastCode    = scanCode == 8'hFF;
    assign ready       = state == SERVE;
    assign accept      = ready && labelValid;
    assign lookupBad   = labelIn == 8'd0 || labelIn > {2'b00, LAST_LABEL};
    assign rdIdx       = labelIn[5:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BUILD;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            BUILD: if (lastCode) stateNext = SERVE;
            SERVE: stateNext = SERVE;
            default: stateNext = BUILD;
        endcase
    end

    // scanCode parks at 255 once the scan completes.
    always_ff @(posedge clock) begin
        if (reset) begin
            scanCode  <= 8'd0;
            nextLabel <= 6'd1;
        end else if (state == BUILD) begin
            if (!lastCode) begin
                scanCode <= scanCode + 8'd1;
            end
            if (scanUniform) begin
                nextLabel <= nextLabel + 6'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && state == BUILD && scanUniform
            && nextLabel <= LAST_LABEL) begin
            tbl[nextLabel] <= scanCode;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            patternOut   <= 8'h00;
            patternValid <= 1'b0;
            labelError   <= 1'b0;
        end else begin
            patternValid <= accept;
            if (accept) begin
                labelError <= lookupBad;
                patternOut <= lookupBad ? ERR_PATTERN : tbl[rdIdx];
            end
        end
    end

endmodule
